// File: rtl/excp_sched.sv
// Exception / ertn scheduler: flushes the pipe, waits
// for drain, then redirects fetch to the handler or ERA.
module excp_sched #(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [4:0]  ws_excp,
  input  logic        ws_ertn,
  input  logic        has_int,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        pipe_empty,
  input  logic        redirect_ready,
  output logic        ws_ready,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [31:0] era_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DRAIN_TIMEOUT - 1);

  localparam logic [5:0] EC_INT  = 6'h00;
  localparam logic [5:0] EC_ADEF = 6'h08;
  localparam logic [5:0] EC_ALE  = 6'h09;
  localparam logic [5:0] EC_SYS  = 6'h0B;
  localparam logic [5:0] EC_BRK  = 6'h0C;
  localparam logic [5:0] EC_INE  = 6'h0D;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DRAIN,
    REDIRECT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_pc;
  logic [5:0]    lat_ecode;
  logic          lat_ertn;
  logic [31:0]   rpc_q;

  logic          is_excp;
  logic          trig;
  logic          drain_done;
  logic [5:0]    dec_ecode;

  assign is_excp    = has_int | (|ws_excp);
  assign trig       = ws_valid & (is_excp | ws_ertn);
  assign drain_done = pipe_empty | (cnt == CNT_LAST);

  // Highest-priority cause wins: INT, ADEF, INE, SYS, BRK, ALE.
  always_comb begin
    dec_ecode = EC_INT;
    if (has_int)         dec_ecode = EC_INT;
    else if (ws_excp[0]) dec_ecode = EC_ADEF;
    else if (ws_excp[1]) dec_ecode = EC_INE;
    else if (ws_excp[2]) dec_ecode = EC_SYS;
    else if (ws_excp[3]) dec_ecode = EC_BRK;
    else if (ws_excp[4]) dec_ecode = EC_ALE;
  end

  // Sequencer: latch event, flush, drain, redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_pc    <= '0;
      lat_ecode <= '0;
      lat_ertn  <= 1'b0;
      rpc_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            state     <= FLUSH;
            lat_pc    <= ws_pc;
            lat_ecode <= is_excp ? dec_ecode : 6'h00;
            lat_ertn  <= ~is_excp;
          end
        end
        FLUSH: begin
          state <= DRAIN;
          cnt   <= '0;
        end
        DRAIN: begin
          if (drain_done) begin
            state <= REDIRECT;
            rpc_q <= lat_ertn ? csr_era : csr_eentry;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  assign ws_ready       = (state == IDLE);
  assign busy           = (state != IDLE);
  assign excp_flush     = (state == FLUSH) & ~lat_ertn;
  assign ertn_flush     = (state == FLUSH) & lat_ertn;
  assign era_out        = excp_flush ? lat_pc : 32'h0;
  assign ecode_out      = excp_flush ? lat_ecode : 6'h0;
  assign esubcode_out   = 9'h0;
  assign redirect_valid = (state == REDIRECT);
  assign redirect_pc    = rpc_q;

endmodule
